// File: rtl/rgb_pwm.sv
// PWM driver for the three RGB LED pins; colour and duty are shadowed at period boundaries.
// Optional breathing ramp enabled by defining RGB_PWM_BREATH_EN.
module rgb_pwm #(
    parameter int CNT_W          = 8,
    parameter int PRESCALE       = 16,
    parameter int BRIGHT_DEFAULT = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [2:0]       rgb_in,
    input  logic [CNT_W-1:0] bright,
    input  logic             bright_load,
    output logic [2:0]       led_out,
    output logic             period_start
);

    localparam int               PRE_W   = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(PRESCALE - 1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [PRE_W-1:0] r_pre_cnt;
    logic [CNT_W-1:0] r_pwm_cnt;
    logic [CNT_W-1:0] r_duty_pend;
    logic [CNT_W-1:0] r_duty_sh;
    logic [2:0]       r_rgb_sh;

    logic             w_tick;
    logic             w_boundary;
    logic [CNT_W-1:0] w_ceiling;
    logic [CNT_W-1:0] w_duty_next;

    assign w_tick     = (r_pre_cnt == PRE_MAX);
    assign w_boundary = w_tick && (r_pwm_cnt == CNT_MAX);
    // A load on the boundary cycle itself must take effect in the period that starts now.
    assign w_ceiling  = bright_load ? bright : r_duty_pend;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pre_cnt <= '0;
        end else if (w_tick) begin
            r_pre_cnt <= '0;
        end else begin
            r_pre_cnt <= r_pre_cnt + PRE_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pwm_cnt <= '0;
        end else if (w_tick) begin
            r_pwm_cnt <= r_pwm_cnt + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_duty_pend <= CNT_W'(BRIGHT_DEFAULT);
        end else if (bright_load) begin
            r_duty_pend <= bright;
        end
    end

`ifdef RGB_PWM_BREATH_EN
    logic [CNT_W-1:0] r_breath;
    logic             r_dir_down;
    logic [CNT_W-1:0] w_breath_next;
    logic             w_dir_next;

    // Triangle ramp between 0 and the ceiling, one step per period.
    always_comb begin
        w_breath_next = r_breath;
        w_dir_next    = r_dir_down;
        if (!r_dir_down) begin
            if (r_breath < w_ceiling) begin
                w_breath_next = r_breath + CNT_W'(1);
            end else begin
                w_dir_next    = 1'b1;
                w_breath_next = (r_breath == '0) ? '0 : r_breath - CNT_W'(1);
            end
        end else begin
            if (r_breath != '0) begin
                w_breath_next = r_breath - CNT_W'(1);
            end else begin
                w_dir_next    = 1'b0;
                w_breath_next = (w_ceiling == '0) ? '0 : CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_breath   <= '0;
            r_dir_down <= 1'b0;
        end else if (w_boundary) begin
            r_breath   <= w_breath_next;
            r_dir_down <= w_dir_next;
        end
    end

    assign w_duty_next = w_breath_next;
`else
    assign w_duty_next = w_ceiling;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rgb_sh  <= '0;
            r_duty_sh <= '0;
        end else if (w_boundary) begin
            r_rgb_sh  <= rgb_in;
            r_duty_sh <= w_duty_next;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            led_out      <= '0;
            period_start <= 1'b0;
        end else begin
            led_out      <= r_rgb_sh & {3{r_pwm_cnt < r_duty_sh}};
            period_start <= w_boundary;
        end
    end

endmodule

// File: tb/tb_rgb_pwm.sv
// Directed bench for rgb_pwm with CNT_W=4, PRESCALE=2 (32-cycle period).
// Define RGB_PWM_BREATH_EN for both files to run the breathing sequence instead.
module tb_rgb_pwm;

    localparam int CNT_W  = 4;
    localparam int PERIOD = 32;

    logic             clk;
    logic             rst;
    logic [2:0]       rgb_in;
    logic [CNT_W-1:0] bright;
    logic             bright_load;
    logic [2:0]       led_out;
    logic             period_start;

    int checks   = 0;
    int failures = 0;

    rgb_pwm #(
        .CNT_W          (CNT_W),
        .PRESCALE       (2),
        .BRIGHT_DEFAULT (3)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .rgb_in       (rgb_in),
        .bright       (bright),
        .bright_load  (bright_load),
        .led_out      (led_out),
        .period_start (period_start)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, got, exp);
        end
    endtask

    // Waits (bounded) for period_start; edges = -1 on timeout.
    task automatic wait_ps(output int edges, output int led_nz);
        bit found;
        found  = 1'b0;
        edges  = 0;
        led_nz = 0;
        for (int i = 0; i < 100; i++) begin
            @(posedge clk); #1;
            edges++;
            if (led_out !== 3'b000) led_nz++;
            if (period_start === 1'b1) begin
                found = 1'b1;
                break;
            end
        end
        if (!found) edges = -1;
    endtask

    // Called on a period_start cycle; checks the next full period of led_out.
    task automatic run_period(input string tag, input logic [2:0] exp_rgb, input int exp_hi,
                              input int load_k, input int load_val,
                              input int rgb_k, input logic [2:0] rgb_val);
        int         mism;
        int         ps_mid;
        logic       ps_end;
        logic [2:0] exp;
        mism   = 0;
        ps_mid = 0;
        ps_end = 1'b0;
        for (int k = 0; k < PERIOD; k++) begin
            @(posedge clk); #1;
            exp = (k < exp_hi) ? exp_rgb : 3'b000;
            if (led_out !== exp) mism++;
            if (k < PERIOD - 1 && period_start !== 1'b0) ps_mid++;
            if (k == PERIOD - 1) ps_end = period_start;
            bright_load = 1'b0;
            if (k == load_k) begin
                bright      = CNT_W'(load_val);
                bright_load = 1'b1;
            end
            if (k == rgb_k) rgb_in = rgb_val;
        end
        check({tag, "_pattern_mismatches"}, mism, 0);
        check({tag, "_ps_inside_period"}, ps_mid, 0);
        check({tag, "_ps_at_period_end"}, int'(ps_end), 1);
    endtask

    initial begin
        int edges;
        int led_nz;

        rst         = 1'b1;
        rgb_in      = 3'b000;
        bright      = '0;
        bright_load = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_led_out", int'(led_out), 0);
        check("reset_period_start", int'(period_start), 0);

        // Release reset with red selected and a brightness load.
        rst         = 1'b0;
        rgb_in      = 3'b100;
`ifdef RGB_PWM_BREATH_EN
        bright      = 4'd4;
`else
        bright      = 4'd8;
`endif
        bright_load = 1'b1;
        @(posedge clk); #1;
        bright_load = 1'b0;
        wait_ps(edges, led_nz);
        check("first_ps_latency", (edges < 0) ? -1 : edges + 1, PERIOD);
        check("led_zero_before_first_ps", led_nz, 0);

`ifdef RGB_PWM_BREATH_EN
        begin
            int seq [9] = '{1, 2, 3, 4, 3, 2, 1, 0, 1};
            for (int p = 0; p < 9; p++) begin
                run_period($sformatf("breath_p%0d", p), 3'b100, 2 * seq[p], -1, 0, -1, 3'b000);
            end
        end
`else
        run_period("duty8_a", 3'b100, 16, -1, 0, -1, 3'b000);
        // Load 0 early in this period; it must not affect the current one.
        run_period("duty8_b", 3'b100, 16, 0, 0, -1, 3'b000);
        run_period("duty0", 3'b100, 0, 0, 15, -1, 3'b000);
        // Mid-period colour change must wait for the next boundary.
        run_period("duty15_r", 3'b100, 30, -1, 0, 10, 3'b010);
        run_period("g_only", 3'b010, 30, -1, 0, 10, 3'b110);
        // Load 4 exactly on the boundary cycle: bypass into the next period.
        run_period("rg_duty15", 3'b110, 30, 30, 4, -1, 3'b000);
        run_period("rg_bypass4", 3'b110, 8, -1, 0, 10, 3'b100);

        // Reset in the middle of a period while red is lit.
        repeat (3) @(posedge clk);
        #1;
        check("mid_led_before_reset", int'(led_out), 4);
        rst = 1'b1;
        #1;
        check("async_reset_led_out", int'(led_out), 0);
        check("async_reset_period_start", int'(period_start), 0);
        @(posedge clk); #1;
        rst = 1'b0;
        wait_ps(edges, led_nz);
        check("ps_latency_after_mid_reset", edges, PERIOD);
        check("led_zero_after_mid_reset", led_nz, 0);
        // duty_pend returned to BRIGHT_DEFAULT = 3.
        run_period("default_duty3", 3'b100, 6, -1, 0, -1, 3'b000);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
